// File: rtl/mem_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_router_pkg
// Purpose  : Shared types and constants for the CPU data-side memory router.
//            FSM state encoding, the region-count ceiling, the standard memory
//            map (boot/Wishbone, RAM0, RAM1) and width helper functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_router_pkg;

  localparam int MAX_REGIONS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  // Standard map: boot/Wishbone 0x0000-0x1FFF, RAM0 0x2000-0x27FF,
  // RAM1 0x2800-0x2FFF.
  localparam logic [31:0] c_BOOT_BASE = 32'h0000_0000;
  localparam logic [31:0] c_BOOT_SIZE = 32'h0000_2000;
  localparam logic [31:0] c_RAM0_BASE = 32'h0000_2000;
  localparam logic [31:0] c_RAM0_SIZE = 32'h0000_0800;
  localparam logic [31:0] c_RAM1_BASE = 32'h0000_2800;
  localparam logic [31:0] c_RAM1_SIZE = 32'h0000_0800;

  // Entry 0 sits in the least significant 32 bits.
  localparam logic [3*32-1:0] c_DEFAULT_BASE = {c_RAM0_BASE, c_RAM1_BASE, c_BOOT_BASE};
  localparam logic [3*32-1:0] c_DEFAULT_SIZE = {c_RAM0_SIZE, c_RAM1_SIZE, c_BOOT_SIZE};

  // Width of a region index; a single region still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter width: large enough for TIMEOUT, never below 8 bits.
  function automatic int cnt_width(input int t);
    return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_region_decode.sv
`default_nettype none
// ============================================================================
// Module   : mem_region_decode
// Purpose  : Combinational address decoder. One 33-bit window comparator per
//            region followed by a priority encoder (lowest index wins) and the
//            word offset of the address inside the winning window.
// Ports    : i_addr   - CPU byte address
//            o_hit    - address falls in at least one window
//            o_sel    - index of the winning window (0 when no hit)
//            o_offset - (i_addr - base[o_sel])[31:2] (0 when no hit)
// Revision : 1.0 - initial release
// ============================================================================
module mem_region_decode
  import mem_router_pkg::*;
#(
  parameter int                         NUM_REGIONS = 3,
  parameter int                         SW          = sel_width(NUM_REGIONS),
  parameter logic [NUM_REGIONS*32-1:0]  REGION_BASE = c_DEFAULT_BASE,
  parameter logic [NUM_REGIONS*32-1:0]  REGION_SIZE = c_DEFAULT_SIZE
) (
  input  logic [31:0]   i_addr,
  output logic          o_hit,
  output logic [SW-1:0] o_sel,
  output logic [29:0]   o_offset
);

  logic [NUM_REGIONS-1:0] w_hit_vec;
  logic [31:0]            w_base;
  logic                   w_borrow;

  // Bounds are extended to 33 bits so a window ending exactly at 2^32
  // does not wrap its upper limit to zero.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_cmp
      logic [32:0] w_lo;
      logic [32:0] w_hi;
      assign w_lo          = {1'b0, REGION_BASE[32*gi +: 32]};
      assign w_hi          = w_lo + {1'b0, REGION_SIZE[32*gi +: 32]};
      assign w_hit_vec[gi] = ({1'b0, i_addr} >= w_lo) && ({1'b0, i_addr} < w_hi);
    end
  endgenerate

  // Scan from the top index down so the lowest matching index is the last
  // assignment and therefore wins.
  always_comb begin
    o_hit  = 1'b0;
    o_sel  = '0;
    w_base = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        o_hit  = 1'b1;
        o_sel  = SW'(i);
        w_base = REGION_BASE[32*i +: 32];
      end
    end
  end

  // Word offset computed on the upper 30 bits with the borrow out of the
  // byte lane, which equals (i_addr - w_base)[31:2] exactly.
  assign w_borrow = (i_addr[1:0] < w_base[1:0]);
  assign o_offset = o_hit ? (i_addr[31:2] - w_base[31:2] - {29'd0, w_borrow}) : 30'd0;

endmodule
`default_nettype wire

// File: rtl/mem_router.sv
`default_nettype none
// ============================================================================
// Module   : mem_router
// Purpose  : CPU data-side memory router. Decodes each access against
//            NUM_REGIONS windows, drives a registered strobe to exactly one
//            target until it acks (or the access times out), stalls the CPU
//            meanwhile, registers read data and pulses err_o on unmapped or
//            timed-out accesses.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            rd, wr          - CPU request (exactly one high = valid)
//            addr_i, data_i  - CPU byte address / write data
//            data_o          - registered read data
//            hold_cpu        - CPU stall (combinational)
//            err_o           - one-cycle bus-error pulse
//            t_rd, t_wr      - per-target strobes (one-hot or zero)
//            t_addr_o        - word offset inside the selected window
//            t_data_o        - write data to targets
//            t_data_i, t_ack - packed per-target read data / completion
// Revision : 1.0 - initial release
// ============================================================================
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                         NUM_REGIONS = 3,
  parameter int                         DW          = 32,
  parameter logic [NUM_REGIONS*32-1:0]  REGION_BASE = c_DEFAULT_BASE,
  parameter logic [NUM_REGIONS*32-1:0]  REGION_SIZE = c_DEFAULT_SIZE,
  parameter int                         TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [31:0]               addr_i,
  input  logic [DW-1:0]             data_i,
  output logic [DW-1:0]             data_o,
  output logic                      hold_cpu,
  output logic                      err_o,
  output logic [NUM_REGIONS-1:0]    t_rd,
  output logic [NUM_REGIONS-1:0]    t_wr,
  output logic [29:0]               t_addr_o,
  output logic [DW-1:0]             t_data_o,
  input  logic [NUM_REGIONS*DW-1:0] t_data_i,
  input  logic [NUM_REGIONS-1:0]    t_ack
);

  localparam int               c_SW      = sel_width(NUM_REGIONS);
  localparam int               c_CW      = cnt_width(TIMEOUT);
  // Count value in the last permitted ACCESS cycle.
  localparam logic [c_CW-1:0]  c_TO_LAST = c_CW'(TIMEOUT - 1);

  state_t                 r_state;
  logic [c_SW-1:0]        r_sel;
  logic                   r_is_rd;
  logic [c_CW-1:0]        r_cnt;
  logic [NUM_REGIONS-1:0] r_t_rd;
  logic [NUM_REGIONS-1:0] r_t_wr;
  logic [DW-1:0]          r_data;
  logic                   r_err;

  logic                   w_valid;
  logic                   w_hit;
  logic [c_SW-1:0]        w_sel;
  logic [29:0]            w_offset;
  logic [NUM_REGIONS-1:0] w_onehot;
  logic                   w_ack_sel;
  logic [DW-1:0]          w_tdata [NUM_REGIONS];

  mem_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .SW          (c_SW),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .i_addr   (addr_i),
    .o_hit    (w_hit),
    .o_sel    (w_sel),
    .o_offset (w_offset)
  );

  generate
    for (genvar gr = 0; gr < NUM_REGIONS; gr++) begin : g_unpack
      assign w_tdata[gr] = t_data_i[DW*gr +: DW];
    end
  endgenerate

  // rd and wr together count as no request at all.
  assign w_valid   = rd ^ wr;
  assign w_onehot  = NUM_REGIONS'(1) << w_sel;
  // Only the latched target may complete the access.
  assign w_ack_sel = t_ack[r_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_is_rd <= 1'b0;
      r_cnt   <= '0;
      r_t_rd  <= '0;
      r_t_wr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            if (w_hit) begin
              r_state <= ACCESS;
              r_sel   <= w_sel;
              r_is_rd <= rd;
              r_cnt   <= '0;
              r_t_rd  <= rd ? w_onehot : '0;
              r_t_wr  <= wr ? w_onehot : '0;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // An ack wins over a timeout falling in the same cycle.
          if (w_ack_sel) begin
            r_state <= DONE;
            r_t_rd  <= '0;
            r_t_wr  <= '0;
            if (r_is_rd) begin
              r_data <= w_tdata[r_sel];
            end
          end else if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
            r_state <= ERR;
            r_err   <= 1'b1;
            r_t_rd  <= '0;
            r_t_wr  <= '0;
            r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The stall drops in DONE/ERR so the CPU samples the result on that edge.
  assign hold_cpu = w_valid && (r_state != DONE) && (r_state != ERR);
  assign data_o   = r_data;
  assign err_o    = r_err;
  assign t_rd     = r_t_rd;
  assign t_wr     = r_t_wr;
  assign t_addr_o = w_offset;
  assign t_data_o = data_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_router
// Purpose  : Self-checking bench for mem_router. Five windows (including two
//            overlapping ones and one ending at 2^32), TIMEOUT=4. Transactions
//            are described at transaction level; the expected per-cycle
//            outputs come from the window map and the handshake rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_router;

  localparam int NR = 5;
  localparam int TO = 4;

  localparam logic [31:0] B0 = 32'h0000_0000, S0 = 32'h0000_2000;
  localparam logic [31:0] B1 = 32'h0000_2800, S1 = 32'h0000_0800;
  localparam logic [31:0] B2 = 32'h0000_2000, S2 = 32'h0000_0800;
  localparam logic [31:0] B3 = 32'h0000_2000, S3 = 32'h0000_4000;
  localparam logic [31:0] B4 = 32'hFFFF_F000, S4 = 32'h0000_1000;

  localparam logic [31:0] BASES [NR] = '{B0, B1, B2, B3, B4};
  localparam logic [31:0] SIZES [NR] = '{S0, S1, S2, S3, S4};
  localparam logic [NR*32-1:0] P_BASE = {B4, B3, B2, B1, B0};
  localparam logic [NR*32-1:0] P_SIZE = {S4, S3, S2, S1, S0};

  logic            clk = 1'b0;
  logic            rst, rd, wr;
  logic [31:0]     addr_i, data_i, data_o, t_data_o;
  logic            hold_cpu, err_o;
  logic [NR-1:0]   t_rd, t_wr, t_ack;
  logic [29:0]     t_addr_o;
  logic [NR*32-1:0] t_data_i;

  int n_pass  = 0;
  int n_total = 0;

  logic          chk_en = 1'b0;
  logic [NR-1:0] exp_t_rd, exp_t_wr;
  logic          exp_hold, exp_err;
  logic [31:0]   exp_data;
  logic [29:0]   exp_addr;
  logic [31:0]   m_data;

  mem_router #(
    .NUM_REGIONS (NR),
    .DW          (32),
    .REGION_BASE (P_BASE),
    .REGION_SIZE (P_SIZE),
    .TIMEOUT     (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .hold_cpu (hold_cpu),
    .err_o    (err_o),
    .t_rd     (t_rd),
    .t_wr     (t_wr),
    .t_addr_o (t_addr_o),
    .t_data_o (t_data_o),
    .t_data_i (t_data_i),
    .t_ack    (t_ack)
  );

  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_region(input logic [31:0] a);
    longint unsigned la, lb, ls;
    la = 64'(a);
    for (int i = 0; i < NR; i++) begin
      lb = 64'(BASES[i]);
      ls = 64'(SIZES[i]);
      if (la >= lb && la < lb + ls) return i;
    end
    return -1;
  endfunction

  function automatic logic [29:0] ref_off(input logic [31:0] a, input int i);
    logic [31:0] d;
    d = a - BASES[i];
    return d[31:2];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("t_rd",     64'(t_rd),     64'(exp_t_rd));
      chk("t_wr",     64'(t_wr),     64'(exp_t_wr));
      chk("hold_cpu", 64'(hold_cpu), 64'(exp_hold));
      chk("err_o",    64'(err_o),    64'(exp_err));
      chk("data_o",   64'(data_o),   64'(exp_data));
      chk("t_data_o", 64'(t_data_o), 64'(data_i));
      if (exp_t_rd != '0 || exp_t_wr != '0)
        chk("t_addr_o", 64'(t_addr_o), 64'(exp_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [NR-1:0] trd, input logic [NR-1:0] twr,
                         input logic h, input logic e);
    exp_t_rd = trd;
    exp_t_wr = twr;
    exp_hold = h;
    exp_err  = e;
    exp_data = m_data;
  endtask

  task automatic noise();
    t_ack = NR'($urandom);
    for (int i = 0; i < NR; i++) t_data_i[i*32 +: 32] = $urandom;
  endtask

  // One CPU transaction. wait_n = ACCESS cycles before the ack; when the ack
  // would land after TO strobe cycles the access times out instead.
  task automatic txn(input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] wd, input int wait_n, input logic [31:0] rdv);
    int            ri;
    logic [NR-1:0] oh;
    bit            acked;
    ri = ref_region(a);
    rd = r; wr = w; addr_i = a; data_i = wd;
    noise();
    set_exp('0, '0, r ^ w, 1'b0);
    step();
    if (r == w) return;
    if (ri < 0) begin
      noise();
      set_exp('0, '0, 1'b0, 1'b1);
      step();
      return;
    end
    oh = NR'(1) << ri;
    acked = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      noise();
      t_ack[ri] = (k == wait_n + 1);
      t_data_i[ri*32 +: 32] = rdv;
      set_exp(r ? oh : '0, w ? oh : '0, 1'b1, 1'b0);
      exp_addr = ref_off(a, ri);
      step();
      if (k == wait_n + 1) begin
        acked = 1'b1;
        if (r) m_data = rdv;
        break;
      end
    end
    noise();
    set_exp('0, '0, 1'b0, !acked);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr_i = '0; data_i = '0;
    t_ack = '0; t_data_i = '0; m_data = '0;
    exp_t_rd = '0; exp_t_wr = '0; exp_hold = 1'b0; exp_err = 1'b0;
    exp_data = '0; exp_addr = '0;
    step();
    step();
    set_exp('0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Model pinned to hand-computed decode results.
    chk("lit_region_2804", 64'(ref_region(32'h2804)), 64'(1));
    chk("lit_off_2804",    64'(ref_off(32'h2804, 1)), 64'(1));
    chk("lit_region_2010", 64'(ref_region(32'h2010)), 64'(2));
    chk("lit_off_2010",    64'(ref_off(32'h2010, 2)), 64'(4));
    chk("lit_region_2000", 64'(ref_region(32'h2000)), 64'(2));
    chk("lit_region_3000", 64'(ref_region(32'h3000)), 64'(3));
    chk("lit_region_6000", 64'(ref_region(32'h6000)), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit_region_top",  64'(ref_region(32'hFFFF_FFFC)), 64'(4));

    // Read hit in region 1, minimum latency.
    txn(32'h2804, 1'b1, 1'b0, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lit_read_data",  64'(data_o), 64'h0000_0000_DEAD_BEEF);
    chk("lit_model_data", 64'(m_data), 64'h0000_0000_DEAD_BEEF);
    // Write with 3 wait cycles: data_o must not move.
    txn(32'h2010, 1'b0, 1'b1, 32'hCAFE_0001, 3, 32'h0BAD_0BAD);
    chk("lit_write_keeps_data", 64'(data_o), 64'h0000_0000_DEAD_BEEF);
    // Unmapped read.
    txn(32'h6000, 1'b1, 1'b0, 32'h0, 0, 32'h0);
    // Timeout: target never acks.
    txn(32'h2400, 1'b1, 1'b0, 32'h0, 9, 32'h5555_5555);
    chk("lit_timeout_keeps_data", 64'(data_o), 64'h0000_0000_DEAD_BEEF);
    // Ack in the last permitted cycle still succeeds.
    txn(32'h2000, 1'b1, 1'b0, 32'h0, TO - 1, 32'h1234_5678);
    chk("lit_late_ack_data", 64'(data_o), 64'h0000_0000_1234_5678);
    // rd and wr together: no request.
    txn(32'h2000, 1'b1, 1'b1, 32'h0, 0, 32'h0);
    // Window ending at 2^32.
    txn(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1, 32'hA5A5_5A5A);

    // Reset in the second ACCESS cycle, then a stray ack.
    rd = 1'b1; wr = 1'b0; addr_i = 32'h2000; data_i = $urandom;
    noise(); t_ack = '0;
    set_exp('0, '0, 1'b1, 1'b0);
    step();
    noise(); t_ack = '0;
    set_exp(5'b00100, '0, 1'b1, 1'b0); exp_addr = 30'd0;
    step();
    noise(); t_ack = '0; rst = 1'b1;
    set_exp(5'b00100, '0, 1'b1, 1'b0);
    step();
    m_data = '0;
    rst = 1'b0; rd = 1'b0;
    noise(); t_ack = '1;
    set_exp('0, '0, 1'b0, 1'b0);
    step();
    noise(); t_ack = '1;
    set_exp('0, '0, 1'b0, 1'b0);
    step();
    chk("lit_reset_data", 64'(data_o), 64'h0);

    // Randomized traffic, back-to-back or with idle gaps.
    for (int n = 0; n < 300; n++) begin
      int          k, kind, c, wt;
      logic [31:0] a;
      logic        r, w;
      k    = $urandom_range(0, NR - 1);
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1:    a = BASES[k] + ($urandom % SIZES[k]);
        2:       a = $urandom;
        3:       a = BASES[k] - 32'd1;
        4:       a = BASES[k] + SIZES[k] - 32'd1;
        default: a = BASES[k] + SIZES[k];
      endcase
      c  = $urandom_range(0, 9);
      r  = (c < 4) || (c == 9);
      w  = (c >= 4 && c < 8) || (c == 9);
      wt = $urandom_range(0, 5);
      txn(a, r, w, $urandom, wt, $urandom);
      if ($urandom_range(0, 2) == 0)
        txn($urandom, 1'b0, 1'b0, $urandom, 0, 32'h0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
